// File: rtl/ltc2308_pkg.sv
// Shared types and constants for the LTC2308 ADC link responder.
package ltc2308_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SHIFT   = 2'd2
  } state_t;

  // Bit positions inside the 6-bit config word {S/D,O/S,S1,S0,UNI,SLP}
  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  // Single-ended, unipolar, channel 0
  localparam logic [5:0] CFG_RESET = 6'b100010;

  function automatic logic [2:0] ch_sel_of(input logic [5:0] cfg);
    return {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
  endfunction

endpackage

// File: rtl/ltc2308_responder_sync_edge.sv
// Input synchronizer with registered one-cycle rise/fall pulses.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   rise_reg;
  logic                   fall_reg;
  logic                   level;

  assign level = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      sync_reg[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      prev_reg <= level;
      // Registering the pulse puts it SYNC_STAGES+1 cycles after the pin edge
      rise_reg <= level & ~prev_reg;
      fall_reg <= ~level & prev_reg;
    end
  end

  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule

// File: rtl/ltc2308_responder.sv
// LTC2308 ADC emulator on the CLOCK_50 domain: sample out on SDO, config in on SDI.
// Optional `LTC2308_RESP_BIPOLAR_EN: send MSB-inverted sample when UNI=0.
module ltc2308_responder
  import ltc2308_pkg::*;
#(
  parameter int DATA_W      = 12,
  parameter int CFG_W       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              ADC_SCLK,
  input  logic              ADC_CONVST,
  input  logic              ADC_SDI,
  output logic              ADC_SDO,
  input  logic [DATA_W-1:0] SAMPLE,
  output logic [2:0]        CH_SEL,
  output logic [CFG_W-1:0]  CFG,
  output logic              CFG_VALID,
  output logic              ABORT
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CFG_CNT  = CNT_W'(CFG_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(DATA_W);

  logic sclk_rise, sclk_fall;
  logic convst_rise, convst_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_edge (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .din      (ADC_SCLK),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_convst_edge (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .din      (ADC_CONVST),
    .rise     (convst_rise),
    .fall     (convst_fall)
  );

  // SDI has the same depth as SCLK so its level lines up with the rise pulse
  logic [SYNC_STAGES-1:0] sdi_sync_reg;
  logic                   sdi_level;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sdi_sync_reg <= '0;
    end else begin
      sdi_sync_reg[0] <= ADC_SDI;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sdi_sync_reg[i] <= sdi_sync_reg[i-1];
      end
    end
  end

  assign sdi_level = sdi_sync_reg[SYNC_STAGES-1];

  state_t            state_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CFG_W-1:0]  cfg_shift_reg;
  logic [CFG_W-1:0]  cfg_reg;
  logic [CFG_W-1:0]  cfg_next;
  logic [2:0]        ch_sel_reg;
  logic              sdo_reg;
  logic              cfg_valid_reg;
  logic              abort_reg;
  logic [DATA_W-1:0] tx_word;

`ifdef LTC2308_RESP_BIPOLAR_EN
  assign tx_word = cfg_reg[CFG_UNI] ? SAMPLE
                                    : {~SAMPLE[DATA_W-1], SAMPLE[DATA_W-2:0]};
`else
  assign tx_word = SAMPLE;
`endif

  always_comb begin
    cfg_next = cfg_shift_reg;
    if (cnt_reg < CFG_CNT) begin
      cfg_next = {cfg_shift_reg[CFG_W-2:0], sdi_level};
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      cnt_reg       <= '0;
      cfg_shift_reg <= '0;
      cfg_reg       <= CFG_RESET;
      ch_sel_reg    <= 3'd0;
      sdo_reg       <= 1'b0;
      cfg_valid_reg <= 1'b0;
      abort_reg     <= 1'b0;
    end else begin
      cfg_valid_reg <= 1'b0;
      abort_reg     <= 1'b0;
      // A CONVST rise always restarts the conversion, even over a coincident SCLK edge
      if (convst_rise) begin
        if (state_reg == SHIFT && cnt_reg < DONE_CNT) begin
          abort_reg <= 1'b1;
        end
        shift_reg     <= tx_word;
        ch_sel_reg    <= ch_sel_of(cfg_reg);
        sdo_reg       <= 1'b0;
        cnt_reg       <= '0;
        cfg_shift_reg <= '0;
        state_reg     <= CONVERT;
      end else begin
        case (state_reg)
          IDLE: ;
          CONVERT: begin
            if (convst_fall) begin
              sdo_reg       <= shift_reg[DATA_W-1];
              shift_reg     <= {shift_reg[DATA_W-2:0], 1'b0};
              cnt_reg       <= '0;
              cfg_shift_reg <= '0;
              state_reg     <= SHIFT;
            end
          end
          SHIFT: begin
            if (sclk_rise) begin
              cfg_shift_reg <= cfg_next;
              cnt_reg       <= cnt_reg + 1'b1;
              if (cnt_reg == LAST_CNT) begin
                cfg_reg       <= cfg_next;
                cfg_valid_reg <= 1'b1;
              end
            end else if (sclk_fall) begin
              if (cnt_reg == DONE_CNT) begin
                sdo_reg   <= 1'b0;
                state_reg <= IDLE;
              end else begin
                // Zero fill means SDO naturally reads 0 once every bit is out
                sdo_reg   <= shift_reg[DATA_W-1];
                shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign ADC_SDO   = sdo_reg;
  assign CH_SEL    = ch_sel_reg;
  assign CFG       = cfg_reg;
  assign CFG_VALID = cfg_valid_reg;
  assign ABORT     = abort_reg;

endmodule

// File: tb/tb_ltc2308_responder.sv
// Directed bench for ltc2308_responder acting as an adc_control-style master.
module tb_ltc2308_responder;
  import ltc2308_pkg::*;

  localparam int HALF = 6;

`ifdef LTC2308_RESP_BIPOLAR_EN
  localparam logic [11:0] EXP_BIPOLAR = 12'h000;
`else
  localparam logic [11:0] EXP_BIPOLAR = 12'h800;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk;
  logic        convst;
  logic        sdi;
  logic [11:0] sample;
  logic        sdo;
  logic [2:0]  ch_sel;
  logic [5:0]  cfg;
  logic        cfg_valid;
  logic        abort;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int abort_cnt = 0;

  always #10 clk = ~clk;

  ltc2308_responder dut (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .ADC_SCLK   (sclk),
    .ADC_CONVST (convst),
    .ADC_SDI    (sdi),
    .ADC_SDO    (sdo),
    .SAMPLE     (sample),
    .CH_SEL     (ch_sel),
    .CFG        (cfg),
    .CFG_VALID  (cfg_valid),
    .ABORT      (abort)
  );

  // Counts high cycles, so one count per pulse also proves a one-cycle width
  always @(negedge clk) begin
    if (cfg_valid) valid_cnt++;
    if (abort) abort_cnt++;
  end

  task automatic convst_pulse(input logic [11:0] s);
    sample = s;
    convst = 1'b1;
    repeat (HALF) @(negedge clk);
    convst = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  // n SCLK periods; SDI set in the low phase, SDO read just before each rise
  task automatic sclk_cycles(input int n, input logic [5:0] cfg_word,
                             output logic [11:0] bits, output int valid_lat);
    bits = '0;
    valid_lat = 0;
    for (int i = 0; i < n; i++) begin
      if (i < 6) sdi = cfg_word[5-i];
      else sdi = 1'b0;
      repeat (HALF) @(negedge clk);
      bits = {bits[10:0], sdo};
      sclk = 1'b1;
      for (int k = 1; k <= HALF; k++) begin
        @(negedge clk);
        if (cfg_valid && valid_lat == 0) valid_lat = k;
      end
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; convst = 1'b0; sdi = 1'b0; sample = '0;
    repeat (4) @(negedge clk);
    checks++; if (sdo !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b expected 0", sdo); end
    checks++; if (cfg !== 6'b100010) begin errors++; $display("FAIL reset_cfg: got %b expected 100010", cfg); end
    checks++; if (ch_sel !== 3'd0) begin errors++; $display("FAIL reset_ch_sel: got %0d expected 0", ch_sel); end
    checks++; if (cfg_valid !== 1'b0 || abort !== 1'b0) begin errors++; $display("FAIL reset_pulses: got valid=%b abort=%b expected 0 0", cfg_valid, abort); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    $display("reset: sdo=%b cfg=%b ch_sel=%0d", sdo, cfg, ch_sel);
  endtask

  task automatic test_first_frame();
    logic [11:0] bits; int lat; int v0;
    v0 = valid_cnt;
    convst_pulse(12'hA5C);
    checks++; if (ch_sel !== 3'd0) begin errors++; $display("FAIL frame1_ch_sel: got %0d expected 0", ch_sel); end
    sclk_cycles(12, 6'b110010, bits, lat);
    $display("frame1: sample=a5c sdo=%h cfg=%b valid_lat=%0d", bits, cfg, lat);
    checks++; if (bits !== 12'hA5C) begin errors++; $display("FAIL frame1_sdo: got %h expected a5c", bits); end
    checks++; if (cfg !== 6'b110010) begin errors++; $display("FAIL frame1_cfg: got %b expected 110010", cfg); end
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL frame1_valid_count: got %0d expected 1", valid_cnt - v0); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL frame1_valid_latency: got %0d expected 4", lat); end
    checks++; if (sdo !== 1'b0) begin errors++; $display("FAIL frame1_sdo_idle: got %b expected 0", sdo); end
    checks++; if (ch_sel !== 3'd0) begin errors++; $display("FAIL frame1_ch_sel_end: got %0d expected 0", ch_sel); end
  endtask

  task automatic test_second_frame();
    logic [11:0] bits; int lat; int v0;
    v0 = valid_cnt;
    convst_pulse(12'h3C7);
    checks++; if (ch_sel !== 3'b001) begin errors++; $display("FAIL frame2_ch_sel: got %b expected 001", ch_sel); end
    sclk_cycles(12, 6'b100010, bits, lat);
    $display("frame2: sample=3c7 sdo=%h cfg=%b ch_sel=%b", bits, cfg, ch_sel);
    checks++; if (bits !== 12'h3C7) begin errors++; $display("FAIL frame2_sdo: got %h expected 3c7", bits); end
    checks++; if (cfg !== 6'b100010) begin errors++; $display("FAIL frame2_cfg: got %b expected 100010", cfg); end
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL frame2_valid_count: got %0d expected 1", valid_cnt - v0); end
  endtask

  task automatic test_abort();
    logic [11:0] bits; int lat; int v0; int a0;
    v0 = valid_cnt; a0 = abort_cnt;
    convst_pulse(12'hFFF);
    sclk_cycles(5, 6'b010101, bits, lat);
    convst_pulse(12'h123);
    $display("abort: aborts=%0d cfg=%b", abort_cnt - a0, cfg);
    checks++; if (abort_cnt - a0 !== 1) begin errors++; $display("FAIL abort_count: got %0d expected 1", abort_cnt - a0); end
    checks++; if (cfg !== 6'b100010) begin errors++; $display("FAIL abort_cfg: got %b expected 100010", cfg); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL abort_valid: got %0d expected 0", valid_cnt - v0); end
    sclk_cycles(12, 6'b100010, bits, lat);
    $display("abort_refill: sample=123 sdo=%h", bits);
    checks++; if (bits !== 12'h123) begin errors++; $display("FAIL abort_refill_sdo: got %h expected 123", bits); end
    checks++; if (valid_cnt - v0 !== 1 || abort_cnt - a0 !== 1) begin errors++; $display("FAIL abort_refill_pulses: got valid=%0d abort=%0d expected 1 1", valid_cnt - v0, abort_cnt - a0); end
  endtask

  task automatic test_reset_mid_shift();
    logic [11:0] bits; int lat; int v0;
    convst_pulse(12'h000);
    sclk_cycles(12, 6'b111110, bits, lat);
    convst_pulse(12'hFFF);
    checks++; if (ch_sel !== 3'b111) begin errors++; $display("FAIL midrst_ch_sel_before: got %b expected 111", ch_sel); end
    sclk_cycles(4, 6'b000000, bits, lat);
    checks++; if (sdo !== 1'b1) begin errors++; $display("FAIL midrst_sdo_before: got %b expected 1", sdo); end
    rst = 1'b1;
    #1;
    $display("reset_mid_shift: sdo=%b cfg=%b ch_sel=%b", sdo, cfg, ch_sel);
    checks++; if (sdo !== 1'b0) begin errors++; $display("FAIL midrst_sdo: got %b expected 0", sdo); end
    checks++; if (cfg !== 6'b100010) begin errors++; $display("FAIL midrst_cfg: got %b expected 100010", cfg); end
    checks++; if (ch_sel !== 3'd0) begin errors++; $display("FAIL midrst_ch_sel: got %b expected 000", ch_sel); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    v0 = valid_cnt;
    convst_pulse(12'h5A3);
    checks++; if (ch_sel !== 3'd0) begin errors++; $display("FAIL postrst_ch_sel: got %b expected 000", ch_sel); end
    sclk_cycles(12, 6'b100010, bits, lat);
    $display("post_reset_frame: sample=5a3 sdo=%h valid_lat=%0d", bits, lat);
    checks++; if (bits !== 12'h5A3) begin errors++; $display("FAIL postrst_sdo: got %h expected 5a3", bits); end
    checks++; if (valid_cnt - v0 !== 1 || lat !== 4) begin errors++; $display("FAIL postrst_valid: got count=%0d lat=%0d expected 1 4", valid_cnt - v0, lat); end
  endtask

  task automatic test_bipolar();
    logic [11:0] bits; int lat;
    convst_pulse(12'h0FF);
    sclk_cycles(12, 6'b100000, bits, lat);
    checks++; if (bits !== 12'h0FF) begin errors++; $display("FAIL bipolar_pre_sdo: got %h expected 0ff", bits); end
    checks++; if (cfg !== 6'b100000) begin errors++; $display("FAIL bipolar_cfg: got %b expected 100000", cfg); end
    convst_pulse(12'h800);
    sclk_cycles(12, 6'b100010, bits, lat);
    $display("bipolar: sample=800 uni=0 sdo=%h", bits);
    checks++; if (bits !== EXP_BIPOLAR) begin errors++; $display("FAIL bipolar_sdo: got %h expected %h", bits, EXP_BIPOLAR); end
  endtask

  task automatic test_extra_sclk();
    int v0; logic sdo_hi;
    v0 = valid_cnt;
    sdi = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    sdo_hi = sdo;
    sclk = 1'b0;
    repeat (HALF) @(negedge clk);
    sdi = 1'b0;
    $display("extra_sclk: sdo_high=%b sdo_low=%b valids=%0d state=%0d", sdo_hi, sdo, valid_cnt - v0, dut.state_reg);
    checks++; if (sdo_hi !== 1'b0 || sdo !== 1'b0) begin errors++; $display("FAIL extra_sclk_sdo: got %b%b expected 00", sdo_hi, sdo); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL extra_sclk_valid: got %0d expected 0", valid_cnt - v0); end
    checks++; if (dut.state_reg !== IDLE) begin errors++; $display("FAIL extra_sclk_state: got %0d expected %0d", dut.state_reg, IDLE); end
    checks++; if (cfg !== 6'b100010) begin errors++; $display("FAIL extra_sclk_cfg: got %b expected 100010", cfg); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_second_frame();
    test_abort();
    test_reset_mid_shift();
    test_bipolar();
    test_extra_sclk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
